// File: rtl/sci_alu_sequencer.sv
// sci_alu_sequencer: hands one command at a time to a scientific ALU, holds
// its inputs for a settle window, then captures and presents the result.
// Optional build macro SCI_ALU_SEQ_STATS_EN adds saturating 8-bit counters
// of captured exception and error flags with a synchronous clear.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// SETTLE | ALU inputs held with alu_enable high while the timer runs down
// RESP   | captured result presented until the consumer takes it
module sci_alu_sequencer #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [63:0] cmd_a,
   input  logic [63:0] cmd_b,
   input  logic [3:0]  cmd_op,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_result,
   output logic        rsp_exception,
   output logic        rsp_error,
   output logic        alu_enable,
   output logic [63:0] alu_a,
   output logic [63:0] alu_b,
   output logic [3:0]  alu_opcode,
   input  logic [63:0] alu_result,
   input  logic        alu_exception,
   input  logic        alu_error,
   output logic        busy
`ifdef SCI_ALU_SEQ_STATS_EN
   ,
   input  logic        cnt_clear,
   output logic [7:0]  exc_count,
   output logic [7:0]  err_count
`endif
);

   // A zero settle request is treated as a single settle cycle.
   localparam int         SETTLE_EFF  = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_EFF - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [63:0] alu_a_q, alu_a_d;
   logic [63:0] alu_b_q, alu_b_d;
   logic [3:0]  alu_op_q, alu_op_d;
   logic [63:0] rsp_result_q, rsp_result_d;
   logic        rsp_exc_q, rsp_exc_d;
   logic        rsp_err_q, rsp_err_d;
   logic        capture;

   // Next-state, settle timer and operand/result capture.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      rsp_result_d = rsp_result_q;
      rsp_exc_d    = rsp_exc_q;
      rsp_err_d    = rsp_err_q;
      capture      = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               alu_a_d  = cmd_a;
               alu_b_d  = cmd_b;
               alu_op_d = cmd_op;
               cnt_d    = SETTLE_LOAD;
               state_d  = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q == 4'd0) begin
               capture      = 1'b1;
               rsp_result_d = alu_result;
               rsp_exc_d    = alu_exception;
               rsp_err_d    = alu_error;
               state_d      = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         alu_a_q      <= 64'd0;
         alu_b_q      <= 64'd0;
         alu_op_q     <= 4'd0;
         rsp_result_q <= 64'd0;
         rsp_exc_q    <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         rsp_result_q <= rsp_result_d;
         rsp_exc_q    <= rsp_exc_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign cmd_ready     = (state_q == IDLE);
   assign alu_enable    = (state_q == SETTLE);
   assign rsp_valid     = (state_q == RESP);
   assign busy          = (state_q != IDLE);
   assign alu_a         = alu_a_q;
   assign alu_b         = alu_b_q;
   assign alu_opcode    = alu_op_q;
   assign rsp_result    = rsp_result_q;
   assign rsp_exception = rsp_exc_q;
   assign rsp_error     = rsp_err_q;

`ifdef SCI_ALU_SEQ_STATS_EN
   logic [7:0] exc_count_q, exc_count_d;
   logic [7:0] err_count_q, err_count_d;

   // Saturating flag counters; clear takes priority over a same-cycle capture.
   always_comb begin
      exc_count_d = exc_count_q;
      err_count_d = err_count_q;
      if (cnt_clear) begin
         exc_count_d = 8'd0;
         err_count_d = 8'd0;
      end else if (capture) begin
         if (alu_exception && (exc_count_q != 8'hFF)) exc_count_d = exc_count_q + 8'd1;
         if (alu_error && (err_count_q != 8'hFF))     err_count_d = err_count_q + 8'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exc_count_q <= 8'd0;
         err_count_q <= 8'd0;
      end else begin
         exc_count_q <= exc_count_d;
         err_count_q <= err_count_d;
      end
   end

   assign exc_count = exc_count_q;
   assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_sci_alu_sequencer.sv
// Testbench for sci_alu_sequencer. The bench plays the ALU: its result is only
// meaningful once alu_enable has been held for the settle window, so an early
// capture picks up a poison value.
module tb_sci_alu_sequencer;

   localparam int SC  = 2;
   localparam int EFF = (SC < 1) ? 1 : SC;

   logic        clk, rst_n;
   logic        cmd_valid, cmd_ready;
   logic [63:0] cmd_a, cmd_b;
   logic [3:0]  cmd_op;
   logic        rsp_valid, rsp_ready;
   logic [63:0] rsp_result;
   logic        rsp_exception, rsp_error;
   logic        alu_enable;
   logic [63:0] alu_a, alu_b;
   logic [3:0]  alu_opcode;
   logic [63:0] alu_result;
   logic        alu_exception, alu_error;
   logic        busy;
`ifdef SCI_ALU_SEQ_STATS_EN
   logic        cnt_clear;
   logic [7:0]  exc_count, err_count;
`endif

   int n_cmp = 0;
   int n_err = 0;

   sci_alu_sequencer #(.SETTLE_CYCLES(SC)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_exception(rsp_exception), .rsp_error(rsp_error),
      .alu_enable(alu_enable), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_result(alu_result), .alu_exception(alu_exception), .alu_error(alu_error),
      .busy(busy)
`ifdef SCI_ALU_SEQ_STATS_EN
      , .cnt_clear(cnt_clear), .exc_count(exc_count), .err_count(err_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU behaviour: what a settled ALU returns for a command.
   function automatic logic [63:0] ref_result(logic [63:0] a, logic [63:0] b, logic [3:0] op);
      case (op)
         4'd0:    return $realtobits($bitstoreal(a) + $bitstoreal(b));
         4'd1:    return a - b;
         4'd2:    return a ^ b;
         default: return {a[31:0], b[63:32]} ^ {60'd0, op};
      endcase
   endfunction
   function automatic logic ref_exc(logic [3:0] op);
      return op[3];
   endfunction
   function automatic logic ref_err(logic [3:0] op);
      return op[2] & op[0];
   endfunction

   int en_cnt = 0;
   always @(posedge clk) en_cnt <= alu_enable ? en_cnt + 1 : 0;

   always_comb begin
      alu_result    = 64'hBAD0_BAD0_BAD0_BAD0;
      alu_exception = ~ref_exc(alu_opcode);
      alu_error     = ~ref_err(alu_opcode);
      if (alu_enable && en_cnt >= EFF - 1) begin
         alu_result    = ref_result(alu_a, alu_b, alu_opcode);
         alu_exception = ref_exc(alu_opcode);
         alu_error     = ref_err(alu_opcode);
      end
   end

   int cyc = 0;
   bit log_en = 0;
   int acc_q[$];
   int hs_q[$];
   always @(posedge clk) begin
      if (log_en) begin
         if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
         if (rsp_valid && rsp_ready) hs_q.push_back(cyc);
      end
      cyc++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full command: issue, measure latency, hold the response, hand it off.
   task automatic txn(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                      input int hold);
      int lat;
      logic [63:0] exp;
      @(negedge clk);
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
      chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_a = {$urandom, $urandom}; cmd_b = {$urandom, $urandom}; cmd_op = 4'($urandom);
      chk("alu_enable_set", 64'(alu_enable), 64'd1);
      chk("alu_a", alu_a, a);
      chk("alu_b", alu_b, b);
      chk("alu_opcode", 64'(alu_opcode), 64'(op));
      chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
      lat = 0;
      while (rsp_valid !== 1'b1 && lat <= 20) begin
         chk("alu_enable_settle", 64'(alu_enable), 64'd1);
         chk("alu_a_settle", alu_a, a);
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      exp = ref_result(a, b, op);
      chk("latency", 64'(lat), 64'(EFF));
      chk("rsp_result", rsp_result, exp);
      chk("rsp_exception", 64'(rsp_exception), 64'(ref_exc(op)));
      chk("rsp_error", 64'(rsp_error), 64'(ref_err(op)));
      chk("alu_enable_clr", 64'(alu_enable), 64'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("hold_valid", 64'(rsp_valid), 64'd1);
         chk("hold_result", rsp_result, exp);
         chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
         chk("hold_busy", 64'(busy), 64'd1);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("hs_valid_clr", 64'(rsp_valid), 64'd0);
      chk("hs_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("hs_busy", 64'(busy), 64'd0);
      chk("after_result", rsp_result, exp);
      chk("after_alu_a", alu_a, a);
   endtask

   task automatic drain();
      @(negedge clk);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (EFF + 3) @(negedge clk);
      rsp_ready = 1'b0;
      chk("drain_idle", 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      int seen;
      int found;
      rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_a = '0; cmd_b = '0; cmd_op = '0;
`ifdef SCI_ALU_SEQ_STATS_EN
      cnt_clear = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_alu_enable", 64'(alu_enable), 64'd0);
      chk("rst_alu_a", alu_a, 64'd0);
      chk("rst_rsp_result", rsp_result, 64'd0);
      rst_n = 1'b1;

      // 2.0 + 1.0 = 3.0, responded to immediately
      txn(64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 4'd0, 0);
      chk("sum_literal", rsp_result, 64'h4008_0000_0000_0000);

      // consumer stalls for five cycles
      txn({$urandom, $urandom}, {$urandom, $urandom}, 4'd2, 5);

      // rsp_ready while idle does nothing
      @(negedge clk);
      rsp_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_ready_valid", 64'(rsp_valid), 64'd0);
         chk("idle_ready_cmd", 64'(cmd_ready), 64'd1);
      end
      rsp_ready = 1'b0;

      for (int i = 0; i < 10; i++)
         txn({$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 4)));

      // back-to-back commands with an always-ready consumer
      @(negedge clk);
      cmd_a = {$urandom, $urandom}; cmd_b = {$urandom, $urandom}; cmd_op = 4'd1;
      cmd_valid = 1'b1; rsp_ready = 1'b1; log_en = 1'b1;
      repeat (5 * (EFF + 2) + 1) @(negedge clk);
      log_en = 1'b0;
      drain();
      chk("b2b_count", 64'(acc_q.size() >= 4), 64'd1);
      for (int i = 1; i < acc_q.size(); i++)
         chk("b2b_spacing", 64'(acc_q[i] - acc_q[i-1]), 64'(EFF + 2));
      found = 0;
      foreach (acc_q[i]) foreach (hs_q[j]) if (acc_q[i] == hs_q[j]) found++;
      chk("b2b_no_accept_on_hs", 64'(found), 64'd0);

      // reset during SETTLE abandons the command
      @(negedge clk);
      cmd_a = {$urandom, $urandom}; cmd_b = {$urandom, $urandom}; cmd_op = 4'd3;
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("pre_rst_enable", 64'(alu_enable), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_enable", 64'(alu_enable), 64'd0);
      chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
      chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (2 * EFF + 4) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) seen++;
      end
      chk("no_rsp_after_rst", 64'(seen), 64'd0);
      txn({$urandom, $urandom}, {$urandom, $urandom}, 4'd7, 1);

`ifdef SCI_ALU_SEQ_STATS_EN
      @(negedge clk);
      cnt_clear = 1'b1;
      @(negedge clk);
      cnt_clear = 1'b0;
      chk("stats_cleared", 64'(exc_count), 64'd0);
      @(negedge clk);
      cmd_a = {$urandom, $urandom}; cmd_b = {$urandom, $urandom}; cmd_op = 4'd8;
      cmd_valid = 1'b1; rsp_ready = 1'b1;
      repeat (300 * (EFF + 2)) @(negedge clk);
      drain();
      chk("exc_saturate", 64'(exc_count), 64'd255);
      chk("err_none", 64'(err_count), 64'd0);
      @(negedge clk);
      cmd_op = 4'd13; cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (EFF - 1) @(negedge clk);
      cnt_clear = 1'b1;
      @(negedge clk);
      cnt_clear = 1'b0;
      chk("clr_cap_valid", 64'(rsp_valid), 64'd1);
      chk("clr_wins_exc", 64'(exc_count), 64'd0);
      chk("clr_wins_err", 64'(err_count), 64'd0);
      drain();
      txn({$urandom, $urandom}, {$urandom, $urandom}, 4'd13, 0);
      chk("inc_exc", 64'(exc_count), 64'd1);
      chk("inc_err", 64'(err_count), 64'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global time limit so the bench can never hang.
   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/sci_alu_sequencer.md
SCI_ALU_SEQUENCER -- requirements
Module: sci_alu_sequencer

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 2: clk cycles the ALU inputs are held with alu_enable high before the result is captured (legal range 1..15).
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 cmd_valid  in  1  command request; cmd_ready  out  1  sequencer can accept.
REQ-006 cmd_a, cmd_b  in  64  operands as IEEE-754 double bit patterns; cmd_op  in  4  ALU opcode.
REQ-007 rsp_valid  out  1  response available; rsp_ready  in  1  consumer accepts response.
REQ-008 rsp_result  out  64  captured result bits; rsp_exception, rsp_error  out  1  captured ALU flags.
REQ-009 alu_enable  out  1; alu_a, alu_b  out  64; alu_opcode  out  4: drive scientific ALU enable, a_in, b_in, opcode.
REQ-010 alu_result  in  64; alu_exception, alu_error  in  1: from ALU result_out, exception, error.
REQ-011 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SETTLE, RESP.
REQ-013 In IDLE, cmd_ready SHALL be 1; outside IDLE, cmd_ready SHALL be 0.
REQ-014 On a clk edge with cmd_valid=1 and cmd_ready=1, the block SHALL register cmd_a/cmd_b/cmd_op onto alu_a/alu_b/alu_opcode, set alu_enable=1, load the settle counter, and enter SETTLE.
REQ-015 In SETTLE, alu_enable SHALL stay 1 and alu_a/alu_b/alu_opcode SHALL stay stable for exactly SETTLE_CYCLES cycles.
REQ-016 On the edge ending the last SETTLE cycle, the block SHALL capture alu_result/alu_exception/alu_error into rsp_result/rsp_exception/rsp_error, clear alu_enable, set rsp_valid=1, and enter RESP.
REQ-017 Latency: with acceptance at edge t0, rsp_valid SHALL first be 1 after edge t0+SETTLE_CYCLES.
REQ-018 In RESP, rsp_valid and all rsp_* values SHALL stay stable until rsp_ready=1.
REQ-019 When rsp_valid=1 and rsp_ready=1 on an edge, the block SHALL clear rsp_valid and return to IDLE; a new command SHALL NOT be accepted on that same edge.
REQ-020 Minimum command spacing SHALL be SETTLE_CYCLES+2 cycles.
REQ-021 rsp_ready asserted while rsp_valid=0 SHALL have no effect.
REQ-022 Result and flag bits SHALL pass unmodified; the block performs no arithmetic or real conversion.
REQ-023 After a transaction, alu_a/alu_b/alu_opcode and rsp_result/rsp_exception/rsp_error SHALL hold their last values until the next capture.
REQ-024 A SETTLE_CYCLES value of 0 SHALL behave as 1.

Reset
REQ-025 While rst_n=0, the FSM SHALL be in IDLE and every output SHALL be 0 except cmd_ready, which SHALL be 1.
REQ-026 Reset asserted in SETTLE or RESP SHALL abandon the in-flight command with no response produced.
REQ-027 After release, the first command SHALL be accepted on the first edge where cmd_valid=1.

Configuration
REQ-028 With SCI_ALU_SEQ_STATS_EN defined, the block SHALL add cnt_clear (in, 1), exc_count (out, 8) and err_count (out, 8).
REQ-029 With SCI_ALU_SEQ_STATS_EN defined, each capture SHALL increment exc_count if the captured exception is 1 and err_count if the captured error is 1.
REQ-030 With SCI_ALU_SEQ_STATS_EN defined, both counters SHALL saturate at 255, reset to 0, and be zeroed synchronously by cnt_clear, with clear winning over a same-cycle increment.
REQ-031 Without SCI_ALU_SEQ_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 SETTLE_CYCLES=2, cmd_a=0x4000000000000000, cmd_b=0x3FF0000000000000, cmd_op=0, ALU returns 0x4008000000000000 -> rsp_valid after edge t0+2, rsp_result=0x4008000000000000, flags 0.
REQ-033 rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, cmd_ready=0, busy=1; rsp_ready=1 -> IDLE next edge, cmd_ready=1.
REQ-034 cmd_valid held 1 with back-to-back commands -> acceptances exactly SETTLE_CYCLES+2 cycles apart, no acceptance on a response-handshake edge.
REQ-035 rst_n pulsed low in SETTLE -> alu_enable=0, rsp_valid=0, cmd_ready=1 immediately, no response follows.
REQ-036 ALU returns exception=1 on 300 consecutive commands (stats enabled) -> exc_count=255; cnt_clear coincident with a capture -> exc_count=0.
